// File: rtl/sys_defs.sv
// Shared pipeline types: physical tags, branch masks, branch tasks and the multiplier stage packet.
package sys_defs;

    localparam int unsigned PHYS_REG_W = 6;
    localparam int unsigned BR_MASK_W  = 4;

    typedef logic [PHYS_REG_W-1:0] PHYS_REG_IDX;
    typedef logic [BR_MASK_W-1:0]  BR_MASK;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        SQUASH  = 2'd1,
        CLEAR   = 2'd2
    } BR_TASK;

    // Control half of a multiplier stage; operand and partial-sum vectors travel alongside at XLEN width.
    typedef struct packed {
        logic        valid;
        MULT_FUNC    func;
        PHYS_REG_IDX dest;
        BR_MASK      b_mask;
    } MULT_STAGE_PACKET;

    function automatic logic rs1_signed(input MULT_FUNC f);
        return (f == MULH) || (f == MULHSU);
    endfunction

    function automatic logic rs2_signed(input MULT_FUNC f);
        return f == MULH;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One partial-product step of the multiplier: adds digit K of the multiplier times the
// multiplicand into the running sum and registers the result with its control packet.
module mult_stage
    import sys_defs::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned W    = 16,
    parameter int unsigned K    = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               kill_i,
    input  BR_MASK             clr_mask_i,
    input  MULT_STAGE_PACKET   pkt_i,
    input  logic [2*XLEN-1:0]  mcand_i,
    input  logic [2*XLEN-1:0]  mplier_i,
    input  logic [2*XLEN-1:0]  sum_i,
    output MULT_STAGE_PACKET   pkt_o,
    output logic [2*XLEN-1:0]  mcand_o,
    output logic [2*XLEN-1:0]  mplier_o,
    output logic [2*XLEN-1:0]  sum_o
);

    localparam int unsigned PW = 2 * XLEN;

    MULT_STAGE_PACKET pkt_d, pkt_q;
    logic [PW-1:0]    mcand_d, mcand_q;
    logic [PW-1:0]    mplier_d, mplier_q;
    logic [PW-1:0]    sum_d, sum_q;
    logic [W-1:0]     digit_c;
    logic [PW-1:0]    pp_c;

    assign digit_c = mplier_i[K*W +: W];
    assign pp_c    = (mcand_i * PW'(digit_c)) << (K * W);

    // Hold (with squash/clear applied) unless the downstream slot frees up; data only moves with a valid op.
    always_comb begin
        pkt_d          = pkt_q;
        pkt_d.valid    = pkt_q.valid & ~kill_i;
        pkt_d.b_mask   = pkt_q.b_mask & ~clr_mask_i;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        sum_d          = sum_q;
        if (load_i) begin
            pkt_d.valid = pkt_i.valid;
            if (pkt_i.valid) begin
                pkt_d        = pkt_i;
                pkt_d.b_mask = pkt_i.b_mask & ~clr_mask_i;
                mcand_d      = mcand_i;
                mplier_d     = mplier_i;
                sum_d        = sum_i + pp_c;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
        end else begin
            pkt_q    <= pkt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sum_q    <= sum_d;
        end
    end

    assign pkt_o    = pkt_q;
    assign mcand_o  = mcand_q;
    assign mplier_o = mplier_q;
    assign sum_o    = sum_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with in-order completion,
// back-pressure from the CDB grant, and branch squash/clear on every in-flight op.
module mult_pipe
    import sys_defs::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  MULT_FUNC          issue_func,
    input  logic [XLEN-1:0]   issue_rs1,
    input  logic [XLEN-1:0]   issue_rs2,
    input  PHYS_REG_IDX       issue_dest,
    input  BR_MASK            issue_b_mask,
    input  BR_MASK            br_id,
    input  BR_TASK            br_task,
    input  logic              cdb_gnt,
    output logic              busy,
    output logic              done_valid,
    output PHYS_REG_IDX       done_dest,
    output logic [XLEN-1:0]   done_value,
    output BR_MASK            done_b_mask
);

    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned W  = PW / NUM_STAGES;

    if ((PW % NUM_STAGES) != 0) begin : g_bad_split
        $error("mult_pipe: NUM_STAGES must divide 2*XLEN");
    end
    if ((NUM_STAGES != 2) && (NUM_STAGES != 4) && (NUM_STAGES != 8)) begin : g_bad_depth
        $error("mult_pipe: NUM_STAGES must be 2, 4 or 8");
    end

    MULT_STAGE_PACKET       in_pkt     [NUM_STAGES];
    logic [PW-1:0]          in_mcand   [NUM_STAGES];
    logic [PW-1:0]          in_mplier  [NUM_STAGES];
    logic [PW-1:0]          in_sum     [NUM_STAGES];
    MULT_STAGE_PACKET       stg_pkt    [NUM_STAGES];
    logic [PW-1:0]          stg_mcand  [NUM_STAGES];
    logic [PW-1:0]          stg_mplier [NUM_STAGES];
    logic [PW-1:0]          stg_sum    [NUM_STAGES];
    logic [NUM_STAGES-1:0]  kill_c;
    logic [NUM_STAGES-1:0]  eff_c;
    logic [NUM_STAGES-1:0]  ready_c;
    logic                   squash_c;
    BR_MASK                 clr_mask_c;
    logic                   unused_tail;

    // Stage inputs, squash kills, and the back-to-front ready chain (squashed slots count as empty).
    always_comb begin
        logic r;
        squash_c   = (br_task == SQUASH);
        clr_mask_c = (br_task == CLEAR) ? br_id : '0;

        in_pkt[0].valid  = issue_valid & ~reset & ~(squash_c & (|(issue_b_mask & br_id)));
        in_pkt[0].func   = issue_func;
        in_pkt[0].dest   = issue_dest;
        in_pkt[0].b_mask = issue_b_mask;
        in_mcand[0]  = rs1_signed(issue_func) ? {{XLEN{issue_rs1[XLEN-1]}}, issue_rs1}
                                              : {{XLEN{1'b0}}, issue_rs1};
        in_mplier[0] = rs2_signed(issue_func) ? {{XLEN{issue_rs2[XLEN-1]}}, issue_rs2}
                                              : {{XLEN{1'b0}}, issue_rs2};
        in_sum[0]    = '0;

        for (int k = 0; k < NUM_STAGES; k++) begin
            kill_c[k] = squash_c & (|(stg_pkt[k].b_mask & br_id));
            eff_c[k]  = stg_pkt[k].valid & ~kill_c[k];
        end

        for (int k = 1; k < NUM_STAGES; k++) begin
            in_pkt[k]       = stg_pkt[k-1];
            in_pkt[k].valid = eff_c[k-1];
            in_mcand[k]     = stg_mcand[k-1];
            in_mplier[k]    = stg_mplier[k-1];
            in_sum[k]       = stg_sum[k-1];
        end

        r = ~eff_c[NUM_STAGES-1] | cdb_gnt;
        ready_c[NUM_STAGES-1] = r;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            r = ~eff_c[k] | r;
            ready_c[k] = r;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        mult_stage #(
            .XLEN (XLEN),
            .W    (W),
            .K    (k)
        ) u_stage (
            .clock      (clock),
            .reset      (reset),
            .load_i     (ready_c[k]),
            .kill_i     (kill_c[k]),
            .clr_mask_i (clr_mask_c),
            .pkt_i      (in_pkt[k]),
            .mcand_i    (in_mcand[k]),
            .mplier_i   (in_mplier[k]),
            .sum_i      (in_sum[k]),
            .pkt_o      (stg_pkt[k]),
            .mcand_o    (stg_mcand[k]),
            .mplier_o   (stg_mplier[k]),
            .sum_o      (stg_sum[k])
        );
    end

    assign unused_tail = ^{stg_mcand[NUM_STAGES-1], stg_mplier[NUM_STAGES-1]};

    assign busy        = ~ready_c[0];
    assign done_valid  = stg_pkt[NUM_STAGES-1].valid;
    assign done_dest   = stg_pkt[NUM_STAGES-1].dest;
    assign done_b_mask = stg_pkt[NUM_STAGES-1].b_mask;
    assign done_value  = (stg_pkt[NUM_STAGES-1].func == MUL) ? stg_sum[NUM_STAGES-1][XLEN-1:0]
                                                             : stg_sum[NUM_STAGES-1][PW-1:XLEN];

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: latency, signed/unsigned high halves, stall, squash, clear and reset.
module tb_mult_pipe;
    import sys_defs::*;

    localparam int unsigned NS = 4;
    localparam int unsigned XL = 32;

    logic            clock;
    logic            reset;
    logic            issue_valid;
    MULT_FUNC        issue_func;
    logic [XL-1:0]   issue_rs1;
    logic [XL-1:0]   issue_rs2;
    PHYS_REG_IDX     issue_dest;
    BR_MASK          issue_b_mask;
    BR_MASK          br_id;
    BR_TASK          br_task;
    logic            cdb_gnt;
    logic            busy;
    logic            done_valid;
    PHYS_REG_IDX     done_dest;
    logic [XL-1:0]   done_value;
    BR_MASK          done_b_mask;

    int n_cmp;
    int n_bad;

    mult_pipe #(.NUM_STAGES(NS), .XLEN(XL)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_func   (issue_func),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_dest   (issue_dest),
        .issue_b_mask (issue_b_mask),
        .br_id        (br_id),
        .br_task      (br_task),
        .cdb_gnt      (cdb_gnt),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_dest    (done_dest),
        .done_value   (done_value),
        .done_b_mask  (done_b_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_func   = MUL;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_dest   = '0;
        issue_b_mask = '0;
        br_id        = '0;
        br_task      = NOTHING;
    endtask

    task automatic set_issue(input MULT_FUNC f, input logic [XL-1:0] a, input logic [XL-1:0] b,
                             input PHYS_REG_IDX d, input BR_MASK m);
        issue_valid  = 1'b1;
        issue_func   = f;
        issue_rs1    = a;
        issue_rs2    = b;
        issue_dest   = d;
        issue_b_mask = m;
    endtask

    // Issues one op with grant held, returns done_valid one cycle early and the outputs at latency.
    task automatic run_op(input MULT_FUNC f, input logic [XL-1:0] a, input logic [XL-1:0] b,
                          output logic early_v, output logic v, output logic [XL-1:0] val);
        cdb_gnt = 1'b1;
        set_issue(f, a, b, 6'd7, 4'b0000);
        step();
        idle();
        step();
        step();
        early_v = done_valid;
        step();
        v   = done_valid;
        val = done_value;
        step();
    endtask

    task automatic test_reset();
        idle();
        cdb_gnt = 1'b1;
        reset   = 1'b1;
        step();
        step();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", done_valid); end
        n_cmp++; if (done_dest !== 6'd0) begin n_bad++; $display("FAIL rst_dest got %h want 0", done_dest); end
        n_cmp++; if (done_value !== 32'd0) begin n_bad++; $display("FAIL rst_value got %h want 0", done_value); end
        n_cmp++; if (done_b_mask !== 4'd0) begin n_bad++; $display("FAIL rst_bmask got %b want 0", done_b_mask); end
        reset = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        cdb_gnt = 1'b1;
        set_issue(MUL, 32'd7, 32'd6, 6'd1, 4'b0000);
        step();
        set_issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 4'b0000);
        step();
        idle();
        step();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_early got %b want 0", done_valid); end
        step();
        n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_v0 got %b want 1", done_valid); end
        n_cmp++; if (done_value !== 32'd42) begin n_bad++; $display("FAIL b2b_val0 got %h want %h", done_value, 32'd42); end
        n_cmp++; if (done_dest !== 6'd1) begin n_bad++; $display("FAIL b2b_dest0 got %h want 1", done_dest); end
        step();
        n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_v1 got %b want 1", done_valid); end
        n_cmp++; if (done_value !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL b2b_val1 got %h want fffffffe", done_value); end
        step();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", done_valid); end
    endtask

    task automatic test_signed();
        logic [1:0]    fv [8] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
        logic [XL-1:0] av [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
        logic [XL-1:0] bv [8] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'h0000_0004, 32'h8000_0000, 32'h0000_0010};
        logic [XL-1:0] ev [8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000,
                                  32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 32'h2345_6780};
        logic          ev_early;
        logic          v;
        logic [XL-1:0] val;
        for (int i = 0; i < 8; i++) begin
            run_op(MULT_FUNC'(fv[i]), av[i], bv[i], ev_early, v, val);
            n_cmp++; if (ev_early !== 1'b0) begin n_bad++; $display("FAIL sgn%0d_early got %b want 0", i, ev_early); end
            n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL sgn%0d_valid got %b want 1", i, v); end
            n_cmp++; if (val !== ev[i]) begin n_bad++; $display("FAIL sgn%0d_value got %h want %h", i, val, ev[i]); end
        end
    endtask

    task automatic test_stall();
        PHYS_REG_IDX   d;
        logic [XL-1:0] want;
        cdb_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_issue(MUL, XL'(i + 1), 32'd100, PHYS_REG_IDX'(i + 1), 4'b0000);
            if (i == 3) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy3 got %b want 0", busy); end
            end
            if (i == 4) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy4 got %b want 1", busy); end
            end
            step();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d_v got %b want 1", c, done_valid); end
            n_cmp++; if (done_dest !== 6'd1) begin n_bad++; $display("FAIL stall_hold%0d_dest got %h want 1", c, done_dest); end
            n_cmp++; if (done_value !== 32'd100) begin n_bad++; $display("FAIL stall_hold%0d_val got %h want 100", c, done_value); end
            step();
        end
        cdb_gnt = 1'b1;
        for (int j = 0; j < 4; j++) begin
            d    = PHYS_REG_IDX'(j + 1);
            want = XL'((j + 1) * 100);
            n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL rel%0d_v got %b want 1", j, done_valid); end
            n_cmp++; if (done_dest !== d) begin n_bad++; $display("FAIL rel%0d_dest got %h want %h", j, done_dest, d); end
            n_cmp++; if (done_value !== want) begin n_bad++; $display("FAIL rel%0d_val got %h want %h", j, done_value, want); end
            step();
        end
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL rel_fifth%0d got %b want 0", j, done_valid); end
            step();
        end
    endtask

    task automatic test_squash();
        cdb_gnt = 1'b1;
        set_issue(MUL, 32'd2, 32'd2, 6'd10, 4'b0001);
        step();
        set_issue(MUL, 32'd3, 32'd5, 6'd11, 4'b0010);
        step();
        set_issue(MUL, 32'd4, 32'd4, 6'd12, 4'b0001);
        step();
        set_issue(MUL, 32'd6, 32'd6, 6'd13, 4'b0001);
        br_task = SQUASH;
        br_id   = 4'b0001;
        step();
        idle();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL sq_c4 got %b want 0", done_valid); end
        step();
        n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL sq_c5_v got %b want 1", done_valid); end
        n_cmp++; if (done_dest !== 6'd11) begin n_bad++; $display("FAIL sq_c5_dest got %h want 0b", done_dest); end
        n_cmp++; if (done_value !== 32'd15) begin n_bad++; $display("FAIL sq_c5_val got %h want f", done_value); end
        n_cmp++; if (done_b_mask !== 4'b0010) begin n_bad++; $display("FAIL sq_c5_mask got %b want 0010", done_b_mask); end
        for (int c = 6; c < 9; c++) begin
            step();
            n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL sq_c%0d got %b want 0", c, done_valid); end
        end
        // A held done packet is dropped by squash even without a grant.
        cdb_gnt = 1'b0;
        set_issue(MUL, 32'd2, 32'd3, 6'd30, 4'b0001);
        step();
        idle();
        step(); step(); step(); step();
        n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL sqst_held got %b want 1", done_valid); end
        br_task = SQUASH;
        br_id   = 4'b0001;
        step();
        idle();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL sqst_drop got %b want 0", done_valid); end
        cdb_gnt = 1'b1;
        step();
    endtask

    task automatic test_clear();
        cdb_gnt = 1'b1;
        set_issue(MUL, 32'd9, 32'd9, 6'd20, 4'b0011);
        step();
        idle();
        br_task = CLEAR;
        br_id   = 4'b0001;
        step();
        br_task = SQUASH;
        br_id   = 4'b0001;
        step();
        idle();
        step();
        n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL clr_v got %b want 1", done_valid); end
        n_cmp++; if (done_dest !== 6'd20) begin n_bad++; $display("FAIL clr_dest got %h want 14", done_dest); end
        n_cmp++; if (done_b_mask !== 4'b0010) begin n_bad++; $display("FAIL clr_mask got %b want 0010", done_b_mask); end
        n_cmp++; if (done_value !== 32'd81) begin n_bad++; $display("FAIL clr_val got %h want 51", done_value); end
        step();
        // Clear while the done packet is stalled.
        cdb_gnt = 1'b0;
        set_issue(MUL, 32'd5, 32'd5, 6'd21, 4'b0011);
        step();
        idle();
        step(); step(); step();
        n_cmp++; if (done_b_mask !== 4'b0011) begin n_bad++; $display("FAIL clst_pre got %b want 0011", done_b_mask); end
        br_task = CLEAR;
        br_id   = 4'b0001;
        step();
        n_cmp++; if (done_b_mask !== 4'b0010) begin n_bad++; $display("FAIL clst_mask got %b want 0010", done_b_mask); end
        br_task = SQUASH;
        br_id   = 4'b0001;
        step();
        n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL clst_survive got %b want 1", done_valid); end
        br_id = 4'b0010;
        step();
        idle();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL clst_kill got %b want 0", done_valid); end
        cdb_gnt = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        cdb_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_issue(MUL, XL'(i + 2), 32'd3, PHYS_REG_IDX'(i + 40), 4'b0000);
            step();
        end
        set_issue(MUL, 32'd9, 32'd9, 6'd43, 4'b0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_c%0d got %b want 0", c, done_valid); end
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        cdb_gnt = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_signed();
        test_stall();
        test_squash();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, meaning the number of pipeline stages; legal values 2, 4, 8.
REQ-002 SHALL have parameter XLEN, default 32, meaning the operand and result width.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port issue_valid  input  1  RS is issuing a multiply this cycle.
REQ-006 SHALL have port issue_func  input  MULT_FUNC  operation select: MUL, MULH, MULHSU or MULHU.
REQ-007 SHALL have port issue_rs1, issue_rs2  input  XLEN each  operand values.
REQ-008 SHALL have port issue_dest  input  PHYS_REG_IDX  destination physical tag.
REQ-009 SHALL have port issue_b_mask  input  BR_MASK  branch dependence mask of the issued instruction.
REQ-010 SHALL have port br_id  input  BR_MASK  one-hot branch being resolved.
REQ-011 SHALL have port br_task  input  BR_TASK  NOTHING, SQUASH or CLEAR.
REQ-012 SHALL have port cdb_gnt  input  1  complete stage accepts the result this cycle.
REQ-013 SHALL have port busy  output  1  combinational; an issue this cycle would not be accepted (feeds RS fu_mult_busy).
REQ-014 SHALL have port done_valid  output  1  registered; result is presented, i.e. a CDB request.
REQ-015 SHALL have ports done_dest (PHYS_REG_IDX), done_value (XLEN) and done_b_mask (BR_MASK), all outputs, all registered from the last stage.

Function
REQ-016 Each stage SHALL hold: valid, func, 2*XLEN extended multiplicand, extended multiplier, 2*XLEN partial sum, dest and b_mask.
REQ-017 Operand extension SHALL be as follows, with W = 2*XLEN/NUM_STAGES:
- MULH: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MUL and MULHU: both operands zero-extended.
- Stage k SHALL add (mcand * mplier[k*W +: W]) << (k*W) to the partial sum, modulo 2^(2*XLEN).
REQ-018 Result selection SHALL be: MUL gives product[XLEN-1:0]; MULH, MULHSU and MULHU give product[2*XLEN-1:XLEN].
REQ-019 An issue at cycle t with no stall SHALL produce done_valid in cycle t+NUM_STAGES.
REQ-020 Advance rule: stage k SHALL advance if stage k+1 is empty or advancing. The last stage advances if cdb_gnt=1 or done_valid=0. Bubbles collapse.
REQ-021 busy SHALL equal stage0.valid AND NOT stage0 advancing; issue_valid while busy=1 SHALL be ignored.
REQ-022 A stalled done packet SHALL hold all done_* outputs constant until cdb_gnt=1.
REQ-023 On br_task=SQUASH, every stage with (b_mask & br_id) != 0 SHALL be invalidated at the edge. An incoming issue with (issue_b_mask & br_id) != 0 SHALL NOT be captured. Squashed slots count as empty for the advance rule in the same cycle.
REQ-024 On br_task=CLEAR, br_id SHALL be cleared from the b_mask of every stage and of the captured issue, including while the pipe is stalled.
REQ-025 When squash and stall occur simultaneously, squash SHALL win: a squashed done packet is dropped even if cdb_gnt=0.
REQ-026 Results SHALL leave the block in issue order; nothing is reordered.

Reset
REQ-027 With reset=1 at an edge, all stage valid bits SHALL clear. done_valid=0, done_dest=0, done_value=0, done_b_mask=0. busy SHALL be 0 in the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight results; no done_valid is produced for them.
REQ-029 Issue inputs SHALL be ignored in any cycle with reset=1.

Structure
REQ-030 MULT_FUNC, PHYS_REG_IDX, BR_MASK and BR_TASK SHALL live in the shared sys_defs package; the stage packet struct MULT_STAGE_PACKET SHALL be added there too.
REQ-031 A single sub-module mult_stage SHALL implement one partial-product step (combinational add plus stage register). mult_pipe SHALL instantiate NUM_STAGES copies via generate and own the advance, squash and clear control.
REQ-032 Elaboration SHALL fail if NUM_STAGES does not divide 2*XLEN.

Verification
REQ-033 Back-to-back throughput: issue MUL 7*6 at cycle 0, then MULHU 0xFFFFFFFF*0xFFFFFFFF at cycle 1, with cdb_gnt=1 -> cycle 4: done_value=42; cycle 5: done_value=0xFFFFFFFE.
REQ-034 Signed and mixed high halves: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-035 Stall handling: hold cdb_gnt=0 and issue 5 multiplies on consecutive cycles -> busy=1 once 4 are held, the 5th is not captured, and done_* stays constant. Release cdb_gnt -> the 4 held results emerge in order on 4 consecutive cycles.
REQ-036 Squash: in-flight b_masks 0b01, 0b10, 0b01 and SQUASH with br_id=0b01 -> only the 0b10 op completes, with its original latency.
REQ-037 Clear: b_mask 0b11 in flight and CLEAR with br_id=0b01 -> done_b_mask=0b10; a later SQUASH with br_id=0b01 does not kill it.
REQ-038 Reset mid-operation: reset for 1 cycle with 3 ops in flight -> no done_valid for 8 cycles; busy=0 after reset.
